// File: rtl/ternary_mac_unit_pkg.sv
// ternary_mac_unit_pkg
//   Shared definitions for the ternary MAC unit: default parameter values,
//   the 2-bit trit weight encodings and the control FSM state type.
//   No ports (package).

package ternary_mac_unit_pkg;

    localparam int N_LANES_DEF = 8;
    localparam int ACT_W_DEF   = 8;
    localparam int ACC_W_DEF   = 24;
    localparam int LEN_W_DEF   = 10;

    // Trit weight codes, one per lane.
    localparam logic [1:0] TRIT_NEG  = 2'b00;
    localparam logic [1:0] TRIT_ZERO = 2'b01;
    localparam logic [1:0] TRIT_POS  = 2'b10;
    localparam logic [1:0] TRIT_INV  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/ternary_mac_unit_lane_sum.sv
// ternary_lane_sum
//   Combinational per-beat dot product of N_LANES signed activations with
//   N_LANES ternary weights. Each lane contributes +act, 0 or -act; the lane
//   results are summed at full precision so no beat can overflow.
// Ports:
//   act  : N_LANES*ACT_W packed activations, lane i = act[ACT_W*i +: ACT_W]
//   wgt  : 2*N_LANES packed trits, lane i = wgt[2*i +: 2]
//   sum  : signed beat sum, SUM_W bits
//   inv  : high when any lane carries the invalid trit code

module ternary_lane_sum
    import ternary_mac_unit_pkg::*;
#(
    parameter int N_LANES = N_LANES_DEF,
    parameter int ACT_W   = ACT_W_DEF,
    parameter int SUM_W   = ACT_W + 1 + $clog2(N_LANES)
) (
    input  logic [N_LANES*ACT_W-1:0] act,
    input  logic [2*N_LANES-1:0]     wgt,
    output logic [SUM_W-1:0]         sum,
    output logic                     inv
);

    // One extra bit over ACT_W covers negating the most negative activation;
    // clog2(N_LANES) more bits cover the growth of the lane adder tree.
    always_comb begin
        logic [SUM_W-1:0] a_ext;
        a_ext = '0;
        sum   = '0;
        inv   = 1'b0;
        for (int i = 0; i < N_LANES; i++) begin
            a_ext = {{(SUM_W-ACT_W){act[ACT_W*i+ACT_W-1]}}, act[ACT_W*i +: ACT_W]};
            case (wgt[2*i +: 2])
                TRIT_POS:  sum = sum + a_ext;
                TRIT_NEG:  sum = sum - a_ext;
                TRIT_ZERO: ;
                default:   inv = 1'b1;   // invalid code: contributes nothing
            endcase
        end
    end

endmodule

// File: rtl/ternary_mac_unit.sv
// ternary_mac_unit
//   Streams cfg_len beats of (activation, ternary weight) vectors and produces
//   one saturating signed dot product per run.
// Ports:
//   clk, reset_n         : clock, asynchronous active-low reset
//   cfg_len, start       : beat count and run request (sampled in IDLE only)
//   busy                 : high while a run is in ACCUM or DONE
//   in_valid/in_ready    : input beat handshake; in_act / in_wgt carry the beat
//   out_valid/out_ready  : result handshake; out_acc / out_sat / out_err
//   fsm_state            : debug view of the control FSM state
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. The source holds its payload stable while valid is high and not
// yet accepted; ready here is decoded from the state register only, so it
// never depends combinationally on valid.

module ternary_mac_unit
    import ternary_mac_unit_pkg::*;
#(
    parameter int N_LANES = N_LANES_DEF,
    parameter int ACT_W   = ACT_W_DEF,
    parameter int ACC_W   = ACC_W_DEF,
    parameter int LEN_W   = LEN_W_DEF
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [LEN_W-1:0]         cfg_len,
    input  logic                     start,
    output logic                     busy,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N_LANES*ACT_W-1:0] in_act,
    input  logic [2*N_LANES-1:0]     in_wgt,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ACC_W-1:0]         out_acc,
    output logic                     out_sat,
    output logic                     out_err,
    output logic [1:0]               fsm_state
);

    localparam int SUM_W = ACT_W + 1 + $clog2(N_LANES);

    state_t           state;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] beat_cnt;
    logic [ACC_W-1:0] acc;
    logic             sat;
    logic             err;

    logic [SUM_W-1:0] lane_sum;
    logic             lane_inv;
    logic [ACC_W:0]   sum_ext;
    logic             clamp;
    logic [ACC_W-1:0] acc_next;
    logic [LEN_W-1:0] cnt_next;

    ternary_lane_sum #(
        .N_LANES (N_LANES),
        .ACT_W   (ACT_W),
        .SUM_W   (SUM_W)
    ) u_lane_sum (
        .act (in_act),
        .wgt (in_wgt),
        .sum (lane_sum),
        .inv (lane_inv)
    );

    // Add in ACC_W+1 bits; the two top bits disagree exactly when the true
    // sum falls outside the ACC_W signed range, and the top bit gives the
    // direction of the clamp.
    always_comb begin
        sum_ext  = {acc[ACC_W-1], acc}
                 + {{(ACC_W+1-SUM_W){lane_sum[SUM_W-1]}}, lane_sum};
        clamp    = sum_ext[ACC_W] ^ sum_ext[ACC_W-1];
        acc_next = sum_ext[ACC_W-1:0];
        if (clamp) begin
            acc_next = sum_ext[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                      : {1'b0, {(ACC_W-1){1'b1}}};
        end
        cnt_next = beat_cnt + LEN_W'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            len_q    <= '0;
            beat_cnt <= '0;
            acc      <= '0;
            sat      <= 1'b0;
            err      <= 1'b0;
            out_acc  <= '0;
            out_sat  <= 1'b0;
            out_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        len_q    <= cfg_len;
                        beat_cnt <= '0;
                        acc      <= '0;
                        sat      <= 1'b0;
                        err      <= 1'b0;
                        if (cfg_len == '0) begin
                            // Empty run: publish a zero result directly.
                            state   <= DONE;
                            out_acc <= '0;
                            out_sat <= 1'b0;
                            out_err <= 1'b0;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        acc      <= acc_next;
                        sat      <= sat | clamp;
                        err      <= err | lane_inv;
                        beat_cnt <= cnt_next;
                        if (cnt_next == len_q) begin
                            // Last beat: the result registers load on the
                            // same edge so out_valid and data rise together.
                            state   <= DONE;
                            out_acc <= acc_next;
                            out_sat <= sat | clamp;
                            out_err <= err | lane_inv;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy      = (state == ACCUM) || (state == DONE);
    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == DONE);
    assign fsm_state = state;

endmodule

// File: tb/tb_ternary_mac_unit.sv
// tb_ternary_mac_unit
//   Self-checking bench for ternary_mac_unit (ACC_W=16 so saturation is
//   reachable). A behavioural integer model computes each run's expected
//   result, which is queued when the run is driven and popped when the DUT
//   presents out_valid.

module tb_ternary_mac_unit;
    import ternary_mac_unit_pkg::*;

    localparam int N  = 8;
    localparam int AW = 8;
    localparam int CW = 16;
    localparam int LW = 10;
    localparam int ACC_MAX = (1 << (CW-1)) - 1;
    localparam int ACC_MIN = -(1 << (CW-1));

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          reset_n;
    logic [LW-1:0] cfg_len;
    logic          start;
    logic          busy;
    logic          in_valid;
    logic          in_ready;
    logic [N*AW-1:0] in_act;
    logic [2*N-1:0]  in_wgt;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_acc;
    logic          out_sat;
    logic          out_err;
    logic [1:0]    fsm_state;

    always #5 clk = ~clk;

    ternary_mac_unit #(
        .N_LANES (N),
        .ACT_W   (AW),
        .ACC_W   (CW),
        .LEN_W   (LW)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cfg_len   (cfg_len),
        .start     (start),
        .busy      (busy),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_act    (in_act),
        .in_wgt    (in_wgt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_acc   (out_acc),
        .out_sat   (out_sat),
        .out_err   (out_err),
        .fsm_state (fsm_state)
    );

    // ---------------- scoreboard ----------------
    logic [CW-1:0] exp_q[$];
    logic [1:0]    exp_flag_q[$];   // {sat, err}
    int n_checks = 0;
    int n_pass   = 0;

    int m_acc;
    bit m_sat;
    bit m_err;

    task automatic model_start();
        m_acc = 0;
        m_sat = 1'b0;
        m_err = 1'b0;
    endtask

    task automatic model_beat(input logic [N*AW-1:0] a, input logic [2*N-1:0] w);
        int s;
        logic signed [AW-1:0] av;
        s = 0;
        for (int i = 0; i < N; i++) begin
            av = a[AW*i +: AW];
            case (w[2*i +: 2])
                2'b10:   s = s + int'(av);
                2'b00:   s = s - int'(av);
                2'b01:   ;
                default: m_err = 1'b1;
            endcase
        end
        m_acc = m_acc + s;
        if (m_acc > ACC_MAX) begin
            m_acc = ACC_MAX;
            m_sat = 1'b1;
        end else if (m_acc < ACC_MIN) begin
            m_acc = ACC_MIN;
            m_sat = 1'b1;
        end
    endtask

    task automatic model_push();
        exp_q.push_back(CW'(m_acc));
        exp_flag_q.push_back({m_sat, m_err});
    endtask

    // ---------------- drivers (all return at posedge+1) ----------------
    task automatic start_run(input int len);
        cfg_len = LW'(len);
        start   = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
    endtask

    task automatic send_beat(input logic [N*AW-1:0] a, input logic [2*N-1:0] w);
        bit ok;
        int t;
        ok = 1'b0;
        t  = 0;
        in_valid = 1'b1;
        in_act   = a;
        in_wgt   = w;
        while (!ok && t < 50) begin
            if (in_ready) ok = 1'b1;
            @(posedge clk); #1;
            t++;
        end
        in_valid = 1'b0;
        n_checks++;
        if (!ok) $display("FAIL beat_accept: in_ready never seen within %0d cycles", t);
        else n_pass++;
    endtask

    task automatic bubble(input int cycles);
        in_valid = 1'b0;
        repeat (cycles) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_out(output bit ok);
        int t;
        t = 0;
        while (!out_valid && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        ok = out_valid;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    function automatic logic [N*AW-1:0] rep_act(input logic [AW-1:0] v);
        logic [N*AW-1:0] r;
        for (int i = 0; i < N; i++) r[AW*i +: AW] = v;
        return r;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", out_valid); else n_pass++;
        n_checks++; if (in_ready !== 1'b0)  $display("FAIL rst_in_ready: got %b want 0", in_ready); else n_pass++;
        n_checks++; if (busy !== 1'b0)      $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (out_acc !== '0)     $display("FAIL rst_out_acc: got %0d want 0", out_acc); else n_pass++;
        n_checks++; if (out_sat !== 1'b0)   $display("FAIL rst_out_sat: got %b want 0", out_sat); else n_pass++;
        n_checks++; if (out_err !== 1'b0)   $display("FAIL rst_out_err: got %b want 0", out_err); else n_pass++;
        n_checks++; if (fsm_state !== 2'(IDLE)) $display("FAIL rst_state: got %0d want %0d", fsm_state, IDLE); else n_pass++;
    endtask

    task automatic test_all_pos();
        logic [CW-1:0] ea;
        logic [1:0]    ef;
        model_start();
        start_run(4);
        n_checks++; if (busy !== 1'b1 || in_ready !== 1'b1) $display("FAIL allpos_accum: busy=%b in_ready=%b want 1/1", busy, in_ready); else n_pass++;
        for (int b = 0; b < 4; b++) begin
            if (b == 3) begin
                n_checks++; if (out_valid !== 1'b0) $display("FAIL allpos_early_valid: got %b want 0", out_valid); else n_pass++;
            end
            model_beat(rep_act(8'd1), 16'hAAAA);
            send_beat(rep_act(8'd1), 16'hAAAA);
        end
        model_push();
        // out_valid must already be up one cycle after the last handshake.
        n_checks++; if (out_valid !== 1'b1) $display("FAIL allpos_latency: out_valid=%b want 1", out_valid); else n_pass++;
        n_checks++; if (in_ready !== 1'b0)  $display("FAIL allpos_done_ready: got %b want 0", in_ready); else n_pass++;
        ea = exp_q.pop_front();
        ef = exp_flag_q.pop_front();
        n_checks++; if (out_acc !== ea) $display("FAIL allpos_acc: got %0d want %0d", $signed(out_acc), $signed(ea)); else n_pass++;
        n_checks++; if ({out_sat, out_err} !== ef) $display("FAIL allpos_flags: got %b want %b", {out_sat, out_err}, ef); else n_pass++;
        consume();
        n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0) $display("FAIL allpos_release: out_valid=%b busy=%b want 0/0", out_valid, busy); else n_pass++;
    endtask

    task automatic test_cancel();
        logic [CW-1:0] ea;
        logic [1:0]    ef;
        bit ok;
        for (int pass = 0; pass < 2; pass++) begin
            model_start();
            start_run(2);
            model_beat(rep_act(8'd5), 16'hAAAA);
            send_beat(rep_act(8'd5), 16'hAAAA);
            if (pass == 1) begin
                bubble(3);
                n_checks++; if (fsm_state !== 2'(ACCUM)) $display("FAIL cancel_bubble_state: got %0d want %0d", fsm_state, ACCUM); else n_pass++;
            end
            model_beat(rep_act(8'd5), 16'h0000);
            send_beat(rep_act(8'd5), 16'h0000);
            model_push();
            wait_out(ok);
            n_checks++; if (!ok) $display("FAIL cancel_timeout: out_valid=%b want 1", out_valid); else n_pass++;
            ea = exp_q.pop_front();
            ef = exp_flag_q.pop_front();
            n_checks++; if (out_acc !== ea) $display("FAIL cancel_acc pass%0d: got %0d want %0d", pass, $signed(out_acc), $signed(ea)); else n_pass++;
            n_checks++; if ({out_sat, out_err} !== ef) $display("FAIL cancel_flags pass%0d: got %b want %b", pass, {out_sat, out_err}, ef); else n_pass++;
            consume();
        end
    endtask

    task automatic test_backpressure_sat();
        logic [CW-1:0] ea;
        logic [1:0]    ef;
        model_start();
        start_run(40);
        for (int b = 0; b < 40; b++) begin
            model_beat(rep_act(8'd127), 16'hAAAA);
            send_beat(rep_act(8'd127), 16'hAAAA);
        end
        model_push();
        ea = exp_q.pop_front();
        ef = exp_flag_q.pop_front();
        for (int c = 0; c < 5; c++) begin
            n_checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) $display("FAIL bp_hold c%0d: out_valid=%b in_ready=%b want 1/0", c, out_valid, in_ready); else n_pass++;
            n_checks++; if (out_acc !== ea) $display("FAIL bp_acc c%0d: got %0d want %0d", c, $signed(out_acc), $signed(ea)); else n_pass++;
            n_checks++; if ({out_sat, out_err} !== ef) $display("FAIL bp_flags c%0d: got %b want %b", c, {out_sat, out_err}, ef); else n_pass++;
            start   = (c == 2);
            cfg_len = LW'(3);
            @(posedge clk); #1;
            start   = 1'b0;
        end
        n_checks++; if (fsm_state !== 2'(DONE)) $display("FAIL bp_start_ignored: state=%0d want %0d", fsm_state, DONE); else n_pass++;
        // Start in the handshake cycle must not launch a new run.
        start     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        out_ready = 1'b0;
        n_checks++; if (fsm_state !== 2'(IDLE) || busy !== 1'b0) $display("FAIL bp_hs_start: state=%0d busy=%b want %0d/0", fsm_state, busy, IDLE); else n_pass++;
    endtask

    task automatic test_invalid_trit();
        logic [CW-1:0] ea;
        logic [1:0]    ef;
        bit ok;
        model_start();
        start_run(1);
        model_beat(rep_act(8'd2), 16'hAAEA);
        send_beat(rep_act(8'd2), 16'hAAEA);
        model_push();
        wait_out(ok);
        n_checks++; if (!ok) $display("FAIL inv_timeout: out_valid=%b want 1", out_valid); else n_pass++;
        ea = exp_q.pop_front();
        ef = exp_flag_q.pop_front();
        n_checks++; if (out_acc !== ea) $display("FAIL inv_acc: got %0d want %0d", $signed(out_acc), $signed(ea)); else n_pass++;
        n_checks++; if ({out_sat, out_err} !== ef) $display("FAIL inv_flags: got %b want %b", {out_sat, out_err}, ef); else n_pass++;
        consume();
        bubble(2);
        // Result registers keep their value in IDLE.
        n_checks++; if (out_acc !== ea || out_err !== ef[0]) $display("FAIL inv_retain: acc=%0d err=%b want %0d/%b", $signed(out_acc), out_err, $signed(ea), ef[0]); else n_pass++;
    endtask

    task automatic test_zero_len();
        logic [CW-1:0] ea;
        logic [1:0]    ef;
        model_start();
        model_push();
        in_valid = 1'b1;
        in_act   = rep_act(8'd9);
        in_wgt   = 16'hAAAA;
        start_run(0);
        n_checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) $display("FAIL zero_state: out_valid=%b in_ready=%b want 1/0", out_valid, in_ready); else n_pass++;
        ea = exp_q.pop_front();
        ef = exp_flag_q.pop_front();
        n_checks++; if (out_acc !== ea) $display("FAIL zero_acc: got %0d want %0d", $signed(out_acc), $signed(ea)); else n_pass++;
        n_checks++; if ({out_sat, out_err} !== ef) $display("FAIL zero_flags: got %b want %b", {out_sat, out_err}, ef); else n_pass++;
        consume();
        in_valid = 1'b0;
    endtask

    task automatic test_reset_mid_accum();
        logic [CW-1:0] ea;
        logic [1:0]    ef;
        bit ok;
        start_run(4);
        send_beat(rep_act(8'd7), 16'hAAAA);
        send_beat(rep_act(8'd7), 16'hAAAA);
        reset_n = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0) $display("FAIL midrst_ctrl: busy=%b in_ready=%b out_valid=%b want 0/0/0", busy, in_ready, out_valid); else n_pass++;
        n_checks++; if (out_acc !== '0 || out_sat !== 1'b0 || out_err !== 1'b0) $display("FAIL midrst_data: acc=%0d sat=%b err=%b want 0/0/0", out_acc, out_sat, out_err); else n_pass++;
        @(posedge clk); #2;
        reset_n = 1'b1;
        @(posedge clk); #1;
        model_start();
        start_run(1);
        model_beat(rep_act(8'hFD), 16'hAAAA);
        send_beat(rep_act(8'hFD), 16'hAAAA);
        model_push();
        wait_out(ok);
        n_checks++; if (!ok) $display("FAIL midrst_timeout: out_valid=%b want 1", out_valid); else n_pass++;
        ea = exp_q.pop_front();
        ef = exp_flag_q.pop_front();
        n_checks++; if (out_acc !== ea) $display("FAIL midrst_acc: got %0d want %0d", $signed(out_acc), $signed(ea)); else n_pass++;
        n_checks++; if ({out_sat, out_err} !== ef) $display("FAIL midrst_flags: got %b want %b", {out_sat, out_err}, ef); else n_pass++;
        consume();
    endtask

    task automatic test_random();
        logic [CW-1:0]   ea;
        logic [1:0]      ef;
        logic [N*AW-1:0] a;
        logic [2*N-1:0]  w;
        bit ok;
        int len;
        for (int r = 0; r < 6; r++) begin
            len = $urandom_range(1, 6);
            model_start();
            start_run(len);
            for (int b = 0; b < len; b++) begin
                a = {$urandom(), $urandom()};
                w = 16'($urandom());
                model_beat(a, w);
                send_beat(a, w);
                if ($urandom_range(0, 1) == 1 && b != len - 1) bubble($urandom_range(1, 3));
            end
            model_push();
            bubble($urandom_range(0, 3));
            wait_out(ok);
            n_checks++; if (!ok) $display("FAIL rand_timeout r%0d: out_valid=%b want 1", r, out_valid); else n_pass++;
            ea = exp_q.pop_front();
            ef = exp_flag_q.pop_front();
            n_checks++; if (out_acc !== ea) $display("FAIL rand_acc r%0d: got %0d want %0d", r, $signed(out_acc), $signed(ea)); else n_pass++;
            n_checks++; if ({out_sat, out_err} !== ef) $display("FAIL rand_flags r%0d: got %b want %b", r, {out_sat, out_err}, ef); else n_pass++;
            consume();
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        reset_n   = 1'b0;
        cfg_len   = '0;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_act    = '0;
        in_wgt    = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        reset_n = 1'b1;
        @(posedge clk); #1;
        test_all_pos();
        test_cancel();
        test_backpressure_sat();
        test_invalid_trit();
        test_zero_len();
        test_reset_mid_accum();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
